// File: rtl/sigmoid_inverse.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sigmoid_inverse : Q4.12 logit recovery from a sigmoid output using a     |
// |   fixed-latency binary search over a 29-entry breakpoint ROM; optional   |
// |   in-segment linear interpolation when SIGMOID_INV_INTERP_EN is defined. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sigmoid_inverse (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] y_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] x_out,
  output logic        sat_lo,
  output logic        sat_hi
);

  localparam logic [3:0] SEARCH_LAST = 4'd4;
  localparam logic [3:0] DIV_LAST    = 4'd10;
  localparam logic [4:0] K_MAX       = 5'd28;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SEARCH = 3'd2,
`ifdef SIGMOID_INV_INTERP_EN
    ST_DIV    = 3'd3,
`endif
    ST_DONE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        finish;

  logic [15:0] y_r;
  logic [4:0]  lo;
  logic [4:0]  hi;
  logic [3:0]  cnt;
  logic        run_sat_lo;
  logic        run_sat_hi;

  // T[k] = round(4096 / (1 + exp(-(k-14)/2)))
  function automatic logic [12:0] bp(input logic [4:0] idx);
    case (idx)
      5'd0:  bp = 13'd4;
      5'd1:  bp = 13'd6;
      5'd2:  bp = 13'd10;
      5'd3:  bp = 13'd17;
      5'd4:  bp = 13'd27;
      5'd5:  bp = 13'd45;
      5'd6:  bp = 13'd74;
      5'd7:  bp = 13'd120;
      5'd8:  bp = 13'd194;
      5'd9:  bp = 13'd311;
      5'd10: bp = 13'd488;
      5'd11: bp = 13'd747;
      5'd12: bp = 13'd1102;
      5'd13: bp = 13'd1546;
      5'd14: bp = 13'd2048;
      5'd15: bp = 13'd2550;
      5'd16: bp = 13'd2994;
      5'd17: bp = 13'd3349;
      5'd18: bp = 13'd3608;
      5'd19: bp = 13'd3785;
      5'd20: bp = 13'd3902;
      5'd21: bp = 13'd3976;
      5'd22: bp = 13'd4022;
      5'd23: bp = 13'd4051;
      5'd24: bp = 13'd4069;
      5'd25: bp = 13'd4079;
      5'd26: bp = 13'd4086;
      5'd27: bp = 13'd4090;
      5'd28: bp = 13'd4092;
      default: bp = 13'd0;
    endcase
  endfunction

  // Segment index k-14 in 5-bit two's complement; placed above 11 fraction
  // bits this is exactly (k-14)*2048 as a Q4.12 value.
  function automatic logic [4:0] seg(input logic [4:0] k);
    seg = k - 5'd14;
  endfunction

  // Table-end checks
  logic w_below;
  logic w_above;
  assign w_below = $signed(y_r) <  $signed({3'b000, bp(5'd0)});
  assign w_above = $signed(y_r) >= $signed({3'b000, bp(K_MAX)});

  // One binary-search step
  logic [5:0] w_sum;
  logic [4:0] w_mid;
  logic       w_go_right;
  logic       w_can_step;
  logic [4:0] w_lo_step;
  logic [4:0] w_hi_step;

  assign w_sum      = {1'b0, lo} + {1'b0, hi};
  assign w_mid      = w_sum[5:1];
  assign w_go_right = $signed({3'b000, bp(w_mid)}) <= $signed(y_r);
  assign w_can_step = (hi - lo) > 5'd1;
  assign w_lo_step  = (w_can_step &&  w_go_right) ? w_mid : lo;
  assign w_hi_step  = (w_can_step && !w_go_right) ? w_mid : hi;

`ifdef SIGMOID_INV_INTERP_EN
  // Restoring divider: remainder stays below the segment width (< 512),
  // so each step is a shift, a compare and a conditional subtract.
  logic [12:0] rem;
  logic [10:0] quo;
  logic [12:0] w_t_lo;
  logic [12:0] w_t_hi;
  logic [12:0] w_div;
  logic [12:0] w_rem_cur;
  logic [12:0] w_rem_sh;
  logic        w_ge;
  logic [12:0] w_rem_next;
  logic [10:0] w_quo_next;
  logic [10:0] w_frac;

  assign w_t_lo     = bp(lo);
  assign w_t_hi     = bp(lo + 5'd1);
  assign w_div      = w_t_hi - w_t_lo;
  assign w_rem_cur  = (cnt == 4'd0) ? (y_r[12:0] - w_t_lo) : rem;
  assign w_rem_sh   = {w_rem_cur[11:0], 1'b0};
  assign w_ge       = w_rem_sh >= w_div;
  assign w_rem_next = w_ge ? (w_rem_sh - w_div) : w_rem_sh;
  assign w_quo_next = {quo[9:0], w_ge};
  assign w_frac     = (run_sat_lo || run_sat_hi) ? 11'd0 : w_quo_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    case (state)
      ST_IDLE:   if (start) state_next = ST_CHECK;
      ST_CHECK:  state_next = ST_SEARCH;
      ST_SEARCH: begin
        if (cnt == SEARCH_LAST) begin
`ifdef SIGMOID_INV_INTERP_EN
          state_next = ST_DIV;
`else
          state_next = ST_DONE;
          finish     = 1'b1;
`endif
        end
      end
`ifdef SIGMOID_INV_INTERP_EN
      ST_DIV: begin
        if (cnt == DIV_LAST) begin
          state_next = ST_DONE;
          finish     = 1'b1;
        end
      end
`endif
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      y_r        <= 16'd0;
      lo         <= 5'd0;
      hi         <= 5'd0;
      cnt        <= 4'd0;
      run_sat_lo <= 1'b0;
      run_sat_hi <= 1'b0;
      x_out      <= 16'd0;
      sat_lo     <= 1'b0;
      sat_hi     <= 1'b0;
`ifdef SIGMOID_INV_INTERP_EN
      rem        <= 13'd0;
      quo        <= 11'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) y_r <= y_in;
        end
        ST_CHECK: begin
          cnt <= 4'd0;
          // Saturated runs collapse lo==hi so the search holds for 5 cycles
          if (w_below) begin
            run_sat_lo <= 1'b1;
            run_sat_hi <= 1'b0;
            lo         <= 5'd0;
            hi         <= 5'd0;
          end else if (w_above) begin
            run_sat_lo <= 1'b0;
            run_sat_hi <= 1'b1;
            lo         <= K_MAX;
            hi         <= K_MAX;
          end else begin
            run_sat_lo <= 1'b0;
            run_sat_hi <= 1'b0;
            lo         <= 5'd0;
            hi         <= K_MAX;
          end
        end
        ST_SEARCH: begin
          lo  <= w_lo_step;
          hi  <= w_hi_step;
          cnt <= (cnt == SEARCH_LAST) ? 4'd0 : cnt + 4'd1;
        end
`ifdef SIGMOID_INV_INTERP_EN
        ST_DIV: begin
          rem <= w_rem_next;
          quo <= w_quo_next;
          cnt <= cnt + 4'd1;
        end
`endif
        default: ;
      endcase

      if (finish) begin
`ifdef SIGMOID_INV_INTERP_EN
        x_out <= {seg(lo), w_frac};
`else
        x_out <= {seg(w_lo_step), 11'd0};
`endif
        sat_lo <= run_sat_lo;
        sat_hi <= run_sat_hi;
      end
    end
  end

endmodule
`default_nettype wire
